// File: rtl/gf_pkg.sv
// Shared definitions for the streaming GF(2^m) blocks.
// Mode codes, FSM encoding and a constant clog2 helper.
package gf_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/gf_vec_add_acc_if.sv
// Start/beat/result bundle for gf_vec_add_acc.
// master drives operations, slave is the adder itself.
interface gf_vec_add_acc_if
  import gf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 256
);
  localparam int CW = clog2(MAX_BEATS + 1);
  localparam int VW = WIDTH * LANES;

  logic          i_start;
  logic          i_mode;
  logic [CW-1:0] i_len;
  logic          i_valid;
  logic          o_ready;
  logic [VW-1:0] in_1;
  logic [VW-1:0] in_2;
  logic [VW-1:0] out;
  logic          o_valid;
  logic          o_done;
  logic          o_busy;

  modport master (
    output i_start, i_mode, i_len, i_valid,
    output in_1, in_2,
    input  o_ready, out, o_valid,
    input  o_done, o_busy
  );

  modport slave (
    input  i_start, i_mode, i_len, i_valid,
    input  in_1, in_2,
    output o_ready, out, o_valid,
    output o_done, o_busy
  );
endinterface

// File: rtl/gf_beat_ctr.sv
// Loadable down-counter of remaining beats.
// last flags the final beat, zero an empty count.
module gf_beat_ctr #(
  parameter int CW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          load,
  input  logic [CW-1:0] len,
  input  logic          dec,
  output logic          last,
  output logic          zero
);
  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));
  assign zero = (cnt == '0);
endmodule

// File: rtl/gf_vec_add_acc.sv
// Streaming GF(2^m) vector adder / accumulator.
// ADD emits in_1^in_2 per beat; ACC emits the XOR of all beats.
module gf_vec_add_acc
  import gf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 256
) (
  input logic             i_clk,
  input logic             i_rst,
  gf_vec_add_acc_if.slave bus
);
  localparam int CW = clog2(MAX_BEATS + 1);
  localparam int VW = WIDTH * LANES;

  state_t        state;
  state_t        state_n;
  logic          mode_q;
  logic [VW-1:0] acc;
  logic [VW-1:0] out_q;
  logic          valid_q;
  logic [VW-1:0] sum;
  logic [CW-1:0] len_c;
  logic          start;
  logic          accept;
  logic          last;
  logic          zero;

  assign start  = (state == IDLE) && bus.i_start;
  assign accept = (state == RUN) && bus.i_valid;
  assign sum    = bus.in_1 ^ bus.in_2;

  // Oversized requests saturate instead of wrapping the counter.
  assign len_c = (bus.i_len > CW'(MAX_BEATS))
               ? CW'(MAX_BEATS) : bus.i_len;

  gf_beat_ctr #(.CW(CW)) u_ctr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .load  (start),
    .len   (len_c),
    .dec   (accept),
    .last  (last),
    .zero  (zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.i_start)
              state_n = (len_c == '0) ? FIN : RUN;
      RUN:  if (zero || (accept && last))
              state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q  <= MODE_ADD;
      acc     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (1'b1)
        start: begin
          mode_q <= bus.i_mode;
          acc    <= '0;
          if (bus.i_mode == MODE_ACC && len_c == '0) begin
            out_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        accept && mode_q == MODE_ADD: begin
          out_q   <= sum;
          valid_q <= 1'b1;
        end
        accept && mode_q == MODE_ACC && last: begin
          acc     <= acc ^ sum;
          out_q   <= acc ^ sum;
          valid_q <= 1'b1;
        end
        accept && mode_q == MODE_ACC && !last: begin
          acc <= acc ^ sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ready = (state == RUN);
  assign bus.o_done  = (state == FIN);
  assign bus.o_busy  = (state != IDLE);
endmodule
